alu_cmd_issuer: RTL and testbench

//  Initiator side of the 16-bit ALU port (A,B,F,Cin -> Result,Status). Accepts operation commands over a

---
 rtl/alu_cmd_issuer.sv | 169 ++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_issuer
// Purpose  : Issues commands to a 16-bit ALU, captures Result/Status after one
//            settle cycle and returns tagged responses, tracking the carry flag.
// Revision : 1.0
// ============================================================================
module alu_cmd_issuer #(
  parameter int WIDTH = 16,
  parameter int OPW   = 5,
  parameter int FLAGW = 6,
  parameter int TAGW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [OPW-1:0]   cmd_op,
  input  logic             cmd_use_cf,
  input  logic             cmd_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_f,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [FLAGW-1:0] alu_status,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [FLAGW-1:0] rsp_status,
  output logic             rsp_illegal,
  output logic [TAGW-1:0]  rsp_tag,
  output logic             cf_q,
  input  logic             cf_clr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             rdy_en_q;
  logic             accept;
  logic             capture;
  logic             rsp_hs;

  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_f_q, alu_f_d;
  logic             alu_cin_q, alu_cin_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [FLAGW-1:0] rsp_status_q, rsp_status_d;
  logic             rsp_illegal_q, rsp_illegal_d;
  logic [TAGW-1:0]  tag_q, tag_d;
  logic             cf_d;
  logic             op_bad;

  function automatic logic op_illegal(input logic [OPW-1:0] op);
    logic [31:0] v;
    v = 32'(op);
    return (v == 32'd0) || (v == 32'd2) ||
           ((v >= 32'd12) && (v <= 32'd15)) || (v >= 32'd24);
  endfunction

  // State register; rdy_en_q holds cmd_ready low for the first cycle after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_DRIVE;
      S_DRIVE: state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = accept ? S_DRIVE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    capture   = 1'b0;
    rsp_hs    = 1'b0;
    case (state_q)
      S_IDLE:  cmd_ready = rdy_en_q & ~rst;
      S_DRIVE: capture = 1'b1;
      S_RESP: begin
        rsp_valid = 1'b1;
        cmd_ready = rsp_ready & ~rst;
        rsp_hs    = rsp_ready;
      end
      default: ;
    endcase
  end

  assign accept = cmd_valid & cmd_ready;
  assign op_bad = op_illegal(alu_f_q);

  always_comb begin
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_f_d       = alu_f_q;
    alu_cin_d     = alu_cin_q;
    rsp_result_d  = rsp_result_q;
    rsp_status_d  = rsp_status_q;
    rsp_illegal_d = rsp_illegal_q;
    cf_d          = cf_q;
    tag_d         = tag_q;
    if (accept) begin
      alu_a_d   = cmd_a;
      alu_b_d   = cmd_b;
      alu_f_d   = cmd_op;
      alu_cin_d = cmd_use_cf ? cf_q : cmd_cin;
    end
    if (capture) begin
      rsp_result_d  = alu_result;
      rsp_status_d  = alu_status;
      rsp_illegal_d = op_bad;
      if (!op_bad) cf_d = alu_status[0];
    end
    // An explicit clear overrides a carry captured on the same edge
    if (cf_clr) cf_d = 1'b0;
    if (rsp_hs) tag_d = tag_q + TAGW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_f_q       <= '0;
      alu_cin_q     <= 1'b0;
      rsp_result_q  <= '0;
      rsp_status_q  <= '0;
      rsp_illegal_q <= 1'b0;
      tag_q         <= '0;
      cf_q          <= 1'b0;
    end else begin
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_f_q       <= alu_f_d;
      alu_cin_q     <= alu_cin_d;
      rsp_result_q  <= rsp_result_d;
      rsp_status_q  <= rsp_status_d;
      rsp_illegal_q <= rsp_illegal_d;
      tag_q         <= tag_d;
      cf_q          <= cf_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_f       = alu_f_q;
  assign alu_cin     = alu_cin_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_illegal = rsp_illegal_q;
  assign rsp_tag     = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_issuer
// Purpose  : Scoreboard bench for alu_cmd_issuer with a behavioural ALU.
// Revision : 1.0
// ============================================================================
module tb_alu_cmd_issuer;
  localparam int WIDTH = 16;
  localparam int OPW   = 5;
  localparam int FLAGW = 6;
  localparam int TAGW  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [OPW-1:0]   cmd_op;
  logic             cmd_use_cf, cmd_cin;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [OPW-1:0]   alu_f;
  logic             alu_cin;
  logic [FLAGW-1:0] alu_status;
  logic             rsp_valid, rsp_ready, rsp_illegal;
  logic [WIDTH-1:0] rsp_result;
  logic [FLAGW-1:0] rsp_status;
  logic [TAGW-1:0]  rsp_tag;
  logic             cf_q, cf_clr;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.WIDTH(WIDTH), .OPW(OPW), .FLAGW(FLAGW), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .cmd_use_cf(cmd_use_cf), .cmd_cin(cmd_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_status(alu_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_status(rsp_status),
    .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag),
    .cf_q(cf_q), .cf_clr(cf_clr)
  );

  // Behavioural ALU: Status = {AF,PF,OF,SF,ZF,CF}
  function automatic logic [WIDTH+FLAGW-1:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                                        input logic [4:0] f, input logic cin);
    logic [16:0] s;
    logic [15:0] r;
    case (f)
      5'b00100: s = {1'b0, a} + {1'b0, b};
      5'b00101: s = {1'b0, a} + {1'b0, b} + {16'b0, cin};
      5'b00110: s = {1'b0, a} - {1'b0, b};
      5'b00111: s = {1'b0, a} - {1'b0, b} - {16'b0, cin};
      default:  s = {1'b0, a ^ b};
    endcase
    r = s[15:0];
    return {r, 1'b0, ~^r[7:0], 1'b0, r[15], (r == 16'h0000), s[16]};
  endfunction

  assign {alu_result, alu_status} = alu_model(alu_a, alu_b, alu_f, alu_cin);

  function automatic logic is_illegal(input logic [4:0] op);
    casez (op)
      5'b00000, 5'b00010: return 1'b1;
      5'b011??:           return 1'b1;
      5'b11???:           return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  op;
    logic        cin;
    logic [15:0] res;
    logic [5:0]  st;
    logic        ill;
  } exp_t;

  exp_t       sb[$];
  exp_t       last, cur;
  logic       mon_en = 1'b0;
  logic       exp_cf = 1'b0;
  logic [7:0] exp_tag = 8'd0;
  logic       in_drive = 1'b0;
  logic       cap_legal = 1'b0;
  logic       cap_cf = 1'b0;
  logic       nxt_cf;
  logic       rand_bp = 1'b0;

  // Scoreboard: push on command handshake, pop on response handshake
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("cf_q", 32'(cf_q), 32'(exp_cf));
      if (in_drive) begin
        check_eq("alu_a", 32'(alu_a), 32'(last.a));
        check_eq("alu_b", 32'(alu_b), 32'(last.b));
        check_eq("alu_f", 32'(alu_f), 32'(last.op));
        check_eq("alu_cin", 32'(alu_cin), 32'(last.cin));
      end
      if (!rst && rsp_valid && rsp_ready) begin
        check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          check_eq("rsp_result", 32'(rsp_result), 32'(cur.res));
          check_eq("rsp_status", 32'(rsp_status), 32'(cur.st));
          check_eq("rsp_illegal", 32'(rsp_illegal), 32'(cur.ill));
          check_eq("rsp_tag", 32'(rsp_tag), 32'(exp_tag));
        end
        exp_tag = exp_tag + 8'd1;
      end
      if (rst) begin
        sb.delete();
        exp_cf   = 1'b0;
        exp_tag  = 8'd0;
        in_drive = 1'b0;
      end else begin
        nxt_cf = exp_cf;
        if (in_drive && cap_legal) nxt_cf = cap_cf;
        if (cf_clr) nxt_cf = 1'b0;
        in_drive = 1'b0;
        if (cmd_valid && cmd_ready) begin
          cur.a   = cmd_a;
          cur.b   = cmd_b;
          cur.op  = cmd_op;
          cur.cin = cmd_use_cf ? exp_cf : cmd_cin;
          {cur.res, cur.st} = alu_model(cmd_a, cmd_b, cmd_op, cur.cin);
          cur.ill = is_illegal(cmd_op);
          sb.push_back(cur);
          last      = cur;
          in_drive  = 1'b1;
          cap_legal = !cur.ill;
          cap_cf    = cur.st[0];
        end
        exp_cf = nxt_cf;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) begin
      rsp_ready = ($urandom_range(0, 1) == 1);
      cf_clr    = ($urandom_range(0, 7) == 0);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [4:0] op,
                      input logic use_cf, input logic cin);
    int n = 0;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_use_cf = use_cf; cmd_cin = cin;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) check_eq("accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    while ((sb.size() != 0 || rsp_valid) && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_eq("drain_done", 32'(sb.size() == 0 && !rsp_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    cmd_use_cf = 1'b0; cmd_cin = 1'b0; rsp_ready = 1'b0; cf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
    check_eq("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check_eq("rst_alu_a", 32'(alu_a), 32'd0);
    check_eq("rst_alu_f", 32'(alu_f), 32'd0);
    check_eq("rst_rsp_result", 32'(rsp_result), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("ready_first_cycle", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;

    // ADD 5+4 with latency and held-response checks
    cmd_valid = 1'b1; cmd_a = 16'h0005; cmd_b = 16'h0004; cmd_op = 5'b00100;
    cmd_use_cf = 1'b0; cmd_cin = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("lat_drive_valid", 32'(rsp_valid), 32'd0);
    check_eq("drive_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check_eq("lat_resp_valid", 32'(rsp_valid), 32'd1);
    check_eq("add_result", 32'(rsp_result), 32'h0009);
    repeat (5) begin
      @(negedge clk);
      check_eq("hold_result", 32'(rsp_result), 32'h0009);
      check_eq("hold_status", 32'(rsp_status), 32'h10);
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 16'hFFFF; cmd_b = 16'h0001; cmd_op = 5'b00100;
    @(negedge clk);
    check_eq("b2b_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("carry_result", 32'(rsp_result), 32'h0000);
    check_eq("carry_status", 32'(rsp_status), 32'h13);
    check_eq("carry_cf", 32'(cf_q), 32'd1);
    @(posedge clk); #1;

    // ADC chained on the stored carry
    send(16'h0000, 16'h0000, 5'b00101, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("adc_cin", 32'(alu_cin), 32'd1);
    @(negedge clk);
    check_eq("adc_result", 32'(rsp_result), 32'h0001);
    @(posedge clk); #1;

    // Illegal ops do not touch the carry
    send(16'hFFFF, 16'h0001, 5'b00100, 1'b0, 1'b0);
    send(16'h1234, 16'h00FF, 5'b00000, 1'b0, 1'b0);
    send(16'h0001, 16'h0002, 5'b11010, 1'b0, 1'b0);
    drain();
    check_eq("illegal_keeps_cf", 32'(cf_q), 32'd1);

    // cf_clr during DRIVE of a borrowing SUB
    send(16'h0004, 16'h0005, 5'b00110, 1'b0, 1'b0);
    cf_clr = 1'b1;
    @(posedge clk); #1 cf_clr = 1'b0;
    @(negedge clk);
    check_eq("cf_clr_wins", 32'(cf_q), 32'd0);
    check_eq("sub_borrow", 32'(rsp_status[0]), 32'd1);
    check_eq("sub_result", 32'(rsp_result), 32'hFFFF);
    @(posedge clk); #1;
    drain();

    // Random stream with backpressure and carry clears; long enough to wrap the tag
    rand_bp = 1'b1;
    repeat (270) send(16'($urandom), 16'($urandom), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rand_bp = 1'b0;
    @(posedge clk); #1;
    cf_clr = 1'b0;
    drain();

    // Reset during DRIVE abandons the operation
    send(16'h0007, 16'h0008, 5'b00100, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_mid_tag", 32'(rsp_tag), 32'd0);
    check_eq("rst_mid_ready0", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check_eq("rst_mid_ready1", 32'(cmd_ready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(16'h0002, 16'h0003, 5'b00100, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation still running at t=%0t, required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
